// File: rtl/apb_mem_slave.sv
// APB3 completer with a MEM_DEPTH x 8 register file, programmable wait states,
// and per-location written-since-reset tracking reported through PSLVERR.
module apb_mem_slave #(
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [7:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR
);

  localparam int         AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [8:0] DEPTH = 9'(MEM_DEPTH);
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t               state, state_nxt;
  logic [7:0]           mem [MEM_DEPTH];
  logic [MEM_DEPTH-1:0] valid;
  logic [3:0]           cnt;
  logic                 ready;
  logic [7:0]           addr_p0;
  logic [7:0]           wdata_p0;
  logic                 write_p0;
  logic                 setup;
  logic                 active;
  logic                 commit;
  logic                 addr_ok;
  logic                 hit;
  logic [AW-1:0]        idx;

  assign setup   = (state == IDLE) && PSEL && !PENABLE;
  assign active  = (state == ACCESS) && PSEL && PENABLE;
  assign commit  = active && ready;
  assign idx     = addr_p0[AW-1:0];
  assign addr_ok = {1'b0, addr_p0} < DEPTH;
  assign hit     = addr_ok && valid[idx];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (setup) state_nxt = ACCESS;
      ACCESS:  if (!PSEL || commit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // PREADY is registered, so it is raised on the edge before the cycle it must appear in.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ready <= 1'b0;
      cnt   <= 4'd0;
      valid <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (setup) begin
            cnt   <= WS;
            ready <= (WS == 4'd0);
          end
        end
        ACCESS: begin
          if (!PSEL) begin
            ready <= 1'b0;
          end else if (PENABLE) begin
            if (ready) begin
              ready <= 1'b0;
              if (write_p0 && addr_ok) valid[idx] <= 1'b1;
            end else if (cnt != 4'd0) begin
              cnt   <= cnt - 4'd1;
              ready <= (cnt == 4'd1);
            end
          end
        end
        default: ready <= 1'b0;
      endcase
    end
  end

  // p0: setup-phase capture; bus changes during ACCESS never reach the array.
  always_ff @(posedge PCLK) begin
    if (setup) begin
      addr_p0  <= PADDR;
      wdata_p0 <= PWDATA;
      write_p0 <= PWRITE;
    end
    if (commit && write_p0 && addr_ok) mem[idx] <= wdata_p0;
  end

  always_comb begin
    PREADY  = ready;
    PSLVERR = ready && (write_p0 ? !addr_ok : !hit);
    PRDATA  = (ready && !write_p0 && hit) ? mem[idx] : 8'h00;
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: three builds (WAIT_STATES 1/0/3) on a shared bus,
// vector table plus hand sequences for abort, reset and stray-PENABLE cases.
module tb_apb_mem_slave;

  logic       pclk = 1'b0;
  logic       presetn;
  logic [2:0] psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata  [3];
  logic       pready  [3];
  logic       pslverr [3];

  int tests = 0;
  int fails = 0;

  always #5 pclk = ~pclk;

  apb_mem_slave #(.MEM_DEPTH(64), .WAIT_STATES(1)) dut_ws1 (
    .PCLK(pclk), .PRESETn(presetn), .PSEL(psel[0]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

  apb_mem_slave #(.MEM_DEPTH(64), .WAIT_STATES(0)) dut_ws0 (
    .PCLK(pclk), .PRESETn(presetn), .PSEL(psel[1]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

  apb_mem_slave #(.MEM_DEPTH(64), .WAIT_STATES(3)) dut_ws3 (
    .PCLK(pclk), .PRESETn(presetn), .PSEL(psel[2]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
    .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
    bit         err;
    logic [7:0] rdata;
  } vec_t;

  typedef struct {
    int         lat;
    bit         err;
    logic [7:0] rdata;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[$];

  function automatic int ws_of(input int sel);
    case (sel)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic go_idle();
    @(posedge pclk); #1;
    psel    = 3'b000;
    penable = 1'b0;
  endtask

  // Drives one transfer, scrambling the bus during ACCESS; leaves PSEL/PENABLE
  // high so the following posedge is the completion edge.
  task automatic xfer(input int sel, input bit wr, input logic [7:0] addr,
                      input logic [7:0] data, input bit err,
                      input logic [7:0] rdata, input string name);
    exp_t e;
    int   n;
    bit   seen;
    e.lat   = ws_of(sel) + 1;
    e.err   = err;
    e.rdata = rdata;
    e.name  = name;
    exp_q.push_back(e);
    @(posedge pclk); #1;
    psel      = 3'b000;
    psel[sel] = 1'b1;
    penable   = 1'b0;
    pwrite    = wr;
    paddr     = addr;
    pwdata    = data;
    @(negedge pclk);
    check({name, "_setup_ready"}, 32'(pready[sel]), 32'd0);
    @(posedge pclk); #1;
    penable = 1'b1;
    paddr   = 8'($urandom);
    pwdata  = 8'($urandom);
    pwrite  = 1'($urandom);
    seen    = 1'b0;
    for (n = 1; n <= 20; n++) begin
      @(negedge pclk);
      if (pready[sel]) begin
        seen = 1'b1;
        break;
      end
      @(posedge pclk); #1;
    end
    e = exp_q.pop_front();
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: PREADY not seen in 20 cycles, expected at cycle %0d", e.name, e.lat);
    end else begin
      check({e.name, "_latency"}, 32'(n), 32'(e.lat));
      check({e.name, "_pslverr"}, 32'(pslverr[sel]), 32'(e.err));
      check({e.name, "_prdata"}, 32'(prdata[sel]), 32'(e.rdata));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{1'b1, 8'h03, 8'h06, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 8'h03, 8'h00, 1'b0, 8'h06});
    for (int i = 0; i < 8; i++) vecs.push_back('{1'b1, 8'(i), 8'(2 * i), 1'b0, 8'h00});
    for (int i = 0; i < 8; i++) vecs.push_back('{1'b0, 8'(i), 8'h00, 1'b0, 8'(2 * i)});
    vecs.push_back('{1'b0, 8'h2D, 8'h00, 1'b1, 8'h00});
    vecs.push_back('{1'b1, 8'h10, 8'h35, 1'b0, 8'h00});
    vecs.push_back('{1'b1, 8'h50, 8'hAA, 1'b1, 8'h00});
    vecs.push_back('{1'b0, 8'h50, 8'h00, 1'b1, 8'h00});
    vecs.push_back('{1'b0, 8'h10, 8'h00, 1'b0, 8'h35});
    vecs.push_back('{1'b0, 8'h05, 8'h00, 1'b0, 8'h0A});
    vecs.push_back('{1'b1, 8'h05, 8'h77, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 8'h05, 8'h00, 1'b0, 8'h77});
    vecs.push_back('{1'b0, 8'h2D, 8'h00, 1'b1, 8'h00});

    presetn = 1'b0;
    psel    = 3'b000;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 8'h00;
    pwdata  = 8'h00;
    repeat (2) @(posedge pclk);
    #1;
    for (int s = 0; s < 3; s++) begin
      check($sformatf("reset_ready_%0d", s), 32'(pready[s]), 32'd0);
      check($sformatf("reset_pslverr_%0d", s), 32'(pslverr[s]), 32'd0);
      check($sformatf("reset_prdata_%0d", s), 32'(prdata[s]), 32'd0);
    end
    presetn = 1'b1;

    // Back-to-back table on the WAIT_STATES=1 slave
    for (int i = 0; i < vecs.size(); i++)
      xfer(0, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].err, vecs[i].rdata,
           $sformatf("vec%0d", i));
    go_idle();

    xfer(1, 1'b1, 8'h10, 8'h35, 1'b0, 8'h00, "ws0_wr");
    xfer(1, 1'b0, 8'h10, 8'h00, 1'b0, 8'h35, "ws0_rd");
    xfer(2, 1'b1, 8'h10, 8'h35, 1'b0, 8'h00, "ws3_wr");
    xfer(2, 1'b0, 8'h10, 8'h00, 1'b0, 8'h35, "ws3_rd");
    xfer(2, 1'b0, 8'h11, 8'h00, 1'b1, 8'h00, "ws3_rd_unwritten");
    go_idle();

    // PENABLE with no setup phase must not start a transfer
    @(posedge pclk); #1;
    psel    = 3'b001;
    penable = 1'b1;
    pwrite  = 1'b0;
    paddr   = 8'h03;
    for (int k = 0; k < 3; k++) begin
      @(negedge pclk);
      check($sformatf("stray_enable_ready_%0d", k), 32'(pready[0]), 32'd0);
    end
    go_idle();

    // PSEL dropped in the first access cycle: no commit
    @(posedge pclk); #1;
    psel    = 3'b001;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 8'h08;
    pwdata  = 8'h11;
    @(posedge pclk); #1;
    psel    = 3'b000;
    for (int k = 0; k < 2; k++) begin
      @(negedge pclk);
      check($sformatf("abort_ready_%0d", k), 32'(pready[0]), 32'd0);
    end
    xfer(0, 1'b0, 8'h08, 8'h00, 1'b1, 8'h00, "abort_rd08");

    // Reset pulled in the PREADY cycle of a write
    xfer(0, 1'b1, 8'h07, 8'h0E, 1'b0, 8'h00, "pre_wr07");
    xfer(0, 1'b0, 8'h07, 8'h00, 1'b0, 8'h0E, "pre_rd07");
    @(posedge pclk); #1;
    psel    = 3'b001;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 8'h07;
    pwdata  = 8'hFF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    check("rst_pre_ready", 32'(pready[0]), 32'd1);
    #2 presetn = 1'b0;
    #1;
    check("rst_ready", 32'(pready[0]), 32'd0);
    check("rst_pslverr", 32'(pslverr[0]), 32'd0);
    check("rst_prdata", 32'(prdata[0]), 32'd0);
    psel    = 3'b000;
    penable = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    xfer(0, 1'b0, 8'h07, 8'h00, 1'b1, 8'h00, "post_rst_rd07");
    xfer(0, 1'b0, 8'h03, 8'h00, 1'b1, 8'h00, "post_rst_rd03");
    xfer(1, 1'b0, 8'h10, 8'h00, 1'b1, 8'h00, "post_rst_ws0_rd10");
    xfer(0, 1'b1, 8'h07, 8'h5A, 1'b0, 8'h00, "post_rst_wr07");
    xfer(0, 1'b0, 8'h07, 8'h00, 1'b0, 8'h5A, "post_rst_rd07b");
    go_idle();
    @(negedge pclk);
    check("final_ready", 32'(pready[0]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
